fb_mdu_ctrl: RTL
================

Name: fb_mdu_ctrl

Overview:
Multi-cycle sequencer for the RV32M operations: mul, mulh, mulhsu, mulhu, div, divu, rem and remu. It replaces single-cycle combinational multiply/divide in the execute stage with an iterative radix-2 shift-add / shift-subtract engine behind a start/busy/done handshake. The pipeline stalls on busy. It implements full RISC-V semantics, including mulhsu/mulhu, divide-by-zero and signed overflow.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
EARLY_OUT, 1, 1 = divide-by-zero and signed-overflow cases bypass iteration and finish in 1 cycle.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; accepted only when state is IDLE
op  input  8  one-hot {mul,mulh,mulhsu,mulhu,div,divu,rem,remu}, bit7=mul; same bit order as the alu_control[18:11] field
op1  input  32  rs1 operand, sampled on accept
op2  input  32  rs2 operand, sampled on accept
flush  input  1  abort the current operation (pipeline kill)
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; result valid in the same cycle
result  output  32  registered result; holds its value until the next done

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high (rst).
- rst=1 at an edge: state=IDLE, busy=0, done=0, result=0, all internal registers cleared. This applies mid-operation too.
- States:
  - IDLE: wait for start.
  - CALC: 32 iterations.
  - FIX: sign correction and high/low selection.
  - DONE: done=1 for one cycle, then return to IDLE.
- Accept: start=1 and state=IDLE and op!=0 at edge T.
  - Operands, op and sign flags are latched.
  - op==0 with start: ignored, stays IDLE.
  - Multi-hot op: highest set bit wins (mul > mulh > ... > remu).
- Normal latency:
  - CALC occupies cycles T+1..T+32; counter counts 31 down to 0.
  - FIX occupies T+33; DONE occupies T+34.
  - done and valid result appear in cycle T+34.
  - A new start can be accepted at the edge ending the DONE cycle only if the state is IDLE; DONE is busy, so the next accept is T+35 at the earliest.
- Start while busy: ignored, with no queueing. The requester must hold start until it sees busy=0.
- Multiply:
  - Operate on magnitudes. op1 is treated as signed for mul/mulh/mulhsu; op2 is treated as signed for mul/mulh only.
  - Unsigned 32x32 shift-add builds a 64-bit product.
  - FIX negates the product if the operand signs differ (signed operands only).
  - mul returns product[31:0]; mulh/mulhsu/mulhu return product[63:32].
- Divide/remainder:
  - Magnitudes for div/rem, raw values for divu/remu.
  - Restoring shift-subtract produces a 32-bit quotient and remainder.
  - FIX: quotient is negative iff signs differ; remainder takes the sign of the dividend.
- Special cases (RISC-V spec):
  - op2==0: div/divu -> 0xFFFFFFFF; rem/remu -> op1.
  - Signed overflow (op1=0x80000000, op2=0xFFFFFFFF): div -> 0x80000000; rem -> 0.
  - EARLY_OUT=1: the special case is detected at accept; IDLE->DONE directly, with done in cycle T+1.
  - EARLY_OUT=0: iterate normally. FIX forces the spec values, giving latency T+34.
- Flush:
  - flush=1 at an edge forces IDLE from any state and suppresses done. result keeps its old value.
  - flush and start in the same cycle: flush wins, start is dropped.
  - flush during DONE: the done pulse of that cycle is still seen; the next state is IDLE regardless.
- Outputs:
  - result changes only on entry to DONE.
  - done is never asserted for two consecutive cycles.
  - done=1 implies busy=1.

Test Plan:
- mul, op1=7, op2=0xFFFFFFFD -> done exactly 34 cycles after accept, result=0xFFFFFFEB; busy high 34 cycles.
- mulh 0x80000000*0x80000000 -> 0x40000000; mulhu 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; mulhsu 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- div 0xFFFFFFEC/3 -> 0xFFFFFFFA; rem same operands -> 0xFFFFFFFE; divu 100/7 -> 14; remu 100/7 -> 2.
- EARLY_OUT=1: divu 5/0 -> 0xFFFFFFFF with done 1 cycle after accept; rem 5/0 -> 5; div 0x80000000/0xFFFFFFFF -> 0x80000000; rem same operands -> 0.
- EARLY_OUT=0: same special cases give identical results, with done at T+34.
- Flush/start/reset interplay:
  - Accept mul, pulse flush at cycle T+10 -> busy=0 from T+11, no done, result unchanged.
  - start asserted during busy -> ignored.
  - flush+start in IDLE -> not accepted.
  - rst asserted at T+20 -> busy=0, result=0, no done.

Source files
------------

// File: rtl/fb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fb_mdu_ctrl
// Brief    : Iterative radix-2 RV32M multiply/divide sequencer (start/busy/done)
// Revision : 1.0  initial release
// ============================================================================
module fb_mdu_ctrl #(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [7:0]      op,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int              c_CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] c_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          op_q, op_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [c_CNT_W-1:0]  cnt_q, cnt_d;
    logic                qneg_q, qneg_d;
    logic                rneg_q, rneg_d;
    logic                spec_q, spec_d;
    logic [XLEN-1:0]     spec_val_q, spec_val_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic [7:0]          w_sel;
    logic                w_is_mul, w_n1, w_n2, w_spec, w_div_zero, w_ovf, w_accept;
    logic [XLEN-1:0]     w_mag1, w_mag2, w_spec_val, w_fix, w_lo, w_hi;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN:0]       w_mul_sum, w_rem_sh, w_div_diff;

    // Multi-hot requests collapse onto the highest set bit (mul has priority).
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < 8; i++) begin
            if (op[i]) w_sel = 8'(1) << i;
        end
    end

    always_comb begin
        w_is_mul   = |w_sel[7:4];
        w_n1       = (w_sel[7] | w_sel[6] | w_sel[5] | w_sel[3] | w_sel[1]) & op1[XLEN-1];
        w_n2       = (w_sel[7] | w_sel[6] | w_sel[3] | w_sel[1]) & op2[XLEN-1];
        w_mag1     = w_n1 ? -op1 : op1;
        w_mag2     = w_n2 ? -op2 : op2;
        w_div_zero = ~w_is_mul & (op2 == '0);
        w_ovf      = (w_sel[3] | w_sel[1]) & (op1 == c_MIN) & (op2 == '1);
        w_spec     = w_div_zero | w_ovf;
        if (w_div_zero)
            w_spec_val = (w_sel[3] | w_sel[2]) ? '1 : op1;
        else
            w_spec_val = w_sel[3] ? c_MIN : '0;
        w_accept   = start & (state_q == S_IDLE) & (|op) & ~flush;
    end

    // One iteration of either engine; acc holds {hi, lo} = {partial/rem, multiplier/quotient}.
    always_comb begin
        w_mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
        w_rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        w_div_diff = w_rem_sh - {1'b0, a_q};
    end

    always_comb begin
        w_prod = qneg_q ? -acc_q : acc_q;
        w_lo   = acc_q[XLEN-1:0];
        w_hi   = acc_q[2*XLEN-1:XLEN];
        if (spec_q)                  w_fix = spec_val_q;
        else if (op_q[7])            w_fix = w_prod[XLEN-1:0];
        else if (|op_q[6:4])         w_fix = w_prod[2*XLEN-1:XLEN];
        else if (op_q[3] | op_q[2])  w_fix = qneg_q ? -w_lo : w_lo;
        else if (op_q[1] | op_q[0])  w_fix = rneg_q ? -w_hi : w_hi;
        else                         w_fix = '0;
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        spec_d     = spec_q;
        spec_val_d = spec_val_q;
        result_d   = result_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    op_d       = w_sel;
                    cnt_d      = c_CNT_W'(XLEN-1);
                    qneg_d     = w_n1 ^ w_n2;
                    rneg_d     = w_n1;
                    spec_d     = w_spec;
                    spec_val_d = w_spec_val;
                    a_d        = w_is_mul ? w_mag1 : w_mag2;
                    acc_d      = {{XLEN{1'b0}}, (w_is_mul ? w_mag2 : w_mag1)};
                    if (EARLY_OUT && w_spec) begin
                        state_d  = S_DONE;
                        result_d = w_spec_val;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (|op_q[7:4])
                    acc_d = {w_mul_sum, acc_q[XLEN-1:1]};
                else if (w_div_diff[XLEN])
                    acc_d = {w_rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                else
                    acc_d = {w_div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                if (cnt_q == '0) state_d = S_FIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_FIX: begin
                result_d = w_fix;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        // A kill leaves the published result untouched.
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
            result_q   <= result_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule
`default_nettype wire
